// File: rtl/sr_ctrl_pkg.sv
// Shared state encodings for the S/R button conditioner: the per-button
// debounce channel states and the arbitrated pulse engine states.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } ch_state_t;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_S    = 2'd1,
    P_R    = 2'd2
  } pe_state_t;

endpackage

// File: rtl/sr_debounce_ctrl_channel.sv
// One button channel: two-flop synchronizer, stable-sample debounce FSM and a
// registered one-cycle press strobe on each accepted rising level.
module debounce_channel
  import sr_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            r_meta;
  logic            r_sync;
  ch_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
    end
  end

  // The counter only advances inside ARMING/RELEASING and the state is left
  // at CNT_LAST, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_sync) begin
            r_state <= ARMING;
            r_cnt   <= CW'(1);
          end
        end
        ARMING: begin
          if (!r_sync) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= HELD;
            r_cnt   <= '0;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!r_sync) begin
            r_state <= RELEASING;
            r_cnt   <= CW'(1);
          end
        end
        RELEASING: begin
          if (r_sync) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/sr_debounce_ctrl.sv
// Debounces raw set/reset buttons and arbitrates them into mutually exclusive
// fixed-length S/R pulses for a downstream SR latch.
module sr_debounce_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_LEN       = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic S,
  output logic R,
  output logic conflict,
  output logic busy
);

  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);

  logic [1:0] w_btn;
  logic [1:0] w_press;

  assign w_btn = {rst_btn, set_btn};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (w_btn[gi]),
        .o_press(w_press[gi])
      );
    end
  endgenerate

  pe_state_t     r_pstate;
  logic [PW-1:0] r_pcnt;
  logic          r_s;
  logic          r_r;
  logic          r_busy;
  logic          r_conflict;

  // Any press that cannot be granted exclusively is dropped and flagged;
  // a running pulse always completes its full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate   <= P_IDLE;
      r_pcnt     <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= 1'b0;
      case (r_pstate)
        P_IDLE: begin
          if (w_press[0] && w_press[1]) begin
            r_conflict <= 1'b1;
          end else if (w_press[0]) begin
            r_pstate <= P_S;
            r_pcnt   <= PULSE_LAST;
            r_s      <= 1'b1;
            r_busy   <= 1'b1;
          end else if (w_press[1]) begin
            r_pstate <= P_R;
            r_pcnt   <= PULSE_LAST;
            r_r      <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        P_S, P_R: begin
          if (|w_press) begin
            r_conflict <= 1'b1;
          end
          if (r_pcnt == '0) begin
            r_pstate <= P_IDLE;
            r_s      <= 1'b0;
            r_r      <= 1'b0;
            r_busy   <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt - 1'b1;
          end
        end
        default: begin
          r_pstate <= P_IDLE;
          r_pcnt   <= '0;
          r_s      <= 1'b0;
          r_r      <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign busy     = r_busy;
  assign conflict = r_conflict;

endmodule
